// File: rtl/ccff_loader_pkg.sv
// Shared types and widths for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;
    // Bit count in the shift register ranges 0..WORD_W, so one extra bit.
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : ccff_loader_pkg

// File: rtl/ccff_word_serializer.sv
// One-word skid buffer feeding a 32-bit LSB-first shift register so that a
// steady host stream produces back-to-back serial bits with no word-boundary gap.
module ccff_word_serializer
    import ccff_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic              head_o,
    output logic              has_bits_o
);

    logic [WORD_W-1:0] word_buf_q, word_buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept_c;
    logic              need_reload_c;

    assign wready_o      = load_i && !buf_valid_q;
    assign accept_c      = wvalid_i && wready_o;
    // Reload when empty, or when the last bit leaves on this very edge.
    assign need_reload_c = load_i && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && shift_i));
    assign has_bits_o    = (cnt_q != '0);
    assign head_o        = (cnt_q != '0) ? shreg_q[0] : 1'b0;

    // Next-state for buffer and shift register: shift, reload, capture, flush.
    always_comb begin
        word_buf_d  = word_buf_q;
        buf_valid_d = buf_valid_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;

        if (shift_i) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
        end

        if (need_reload_c) begin
            if (buf_valid_q) begin
                shreg_d     = word_buf_q;
                cnt_d       = CNT_W'(WORD_W);
                buf_valid_d = 1'b0;
            end else if (accept_c) begin
                shreg_d = wdata_i;
                cnt_d   = CNT_W'(WORD_W);
            end
        end

        // A word accepted while the shift register still has work parks in the buffer.
        if (accept_c && !need_reload_c) begin
            word_buf_d  = wdata_i;
            buf_valid_d = 1'b1;
        end

        // Surplus bits of the final word are simply dropped.
        if (flush_i) begin
            buf_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_buf_q  <= '0;
            buf_valid_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
        end else begin
            word_buf_q  <= word_buf_d;
            buf_valid_q <= buf_valid_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule : ccff_word_serializer

// File: rtl/ccff_bitstream_loader.sv
// Streams host words serially into a configuration flip-flop chain, then
// checks that the first bit shifted in has arrived at the chain tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
(
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_bit_q, first_bit_d;
    logic             err_q, err_d;
    logic             has_bits_c;
    logic             in_load_c;
    logic             flush_c;

    assign in_load_c     = (state_q == ST_LOAD);
    assign ccff_shift_en = in_load_c && has_bits_c && (remaining_q != '0);
    // Leaving LOAD for CHECK: discard whatever is left of the last word.
    assign flush_c       = in_load_c && (remaining_q == '0);

    assign busy = in_load_c || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

    ccff_word_serializer u_serializer (
        .clk_i      (prog_clk),
        .rst_i      (reset),
        .load_i     (in_load_c),
        .flush_i    (flush_c),
        .shift_i    (ccff_shift_en),
        .wdata_i    (wdata),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .head_o     (ccff_head),
        .has_bits_o (has_bits_c)
    );

    // Next-state and counter logic for the load sequence.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        first_bit_d = first_bit_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = chain_len;
                    remaining_d = chain_len;
                    err_d       = 1'b0;
                    state_d     = (chain_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ccff_shift_en) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == len_q) begin
                        first_bit_d = ccff_head;
                    end
                end
                if (remaining_q == '0) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (ccff_tail != first_bit_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            len_q       <= '0;
            first_bit_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            first_bit_q <= first_bit_d;
            err_q       <= err_d;
        end
    end

endmodule : ccff_bitstream_loader

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader driving a 16-flop chain model.
module tb_ccff_bitstream_loader;

    logic        prog_clk  = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [15:0] chain_len = 16'd0;
    logic        busy, done, err;
    logic [31:0] wdata     = 32'd0;
    logic        wvalid    = 1'b0;
    logic        wready, ccff_head, ccff_shift_en, ccff_tail;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader dut (
        .prog_clk      (prog_clk),
        .reset         (reset),
        .start         (start),
        .chain_len     (chain_len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .wdata         (wdata),
        .wvalid        (wvalid),
        .wready        (wready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail)
    );

    // Physical 16-flop configuration chain; bit 0 is nearest the head.
    logic [15:0] chain = 16'd0;
    assign ccff_tail = chain[15];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[14:0], ccff_head};
    end

    typedef struct {
        int   len;
        logic first;
        int   exp_stalls;   // -1: not predicted
        logic timed;        // stall-free: done expected at first shift + len + 2
    } rec_t;

    rec_t        exp_q[$];
    logic        exp_bits[$];
    logic [15:0] exp_chain = 16'd0;
    logic [31:0] wq[$];
    int          gq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, start_cyc = 0, first_cyc = -1, last_cyc = -1;
    int nshift = 0, wr_cnt = 0, done_seen = 0;
    logic err_clear_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Monitor: samples at the falling edge, pops expectations on DUT activity.
    initial begin
        forever begin
            rec_t r;
            logic b;
            logic e;
            @(negedge prog_clk);
            cyc++;
            if (!reset) begin
                if (err_clear_pending) begin
                    chk("err_cleared_by_start", 32'(err), 32'd0);
                    err_clear_pending = 1'b0;
                end
                if (start && !busy && !done) begin
                    start_cyc = cyc; first_cyc = -1; last_cyc = -1;
                    nshift = 0; wr_cnt = 0; err_clear_pending = 1'b1;
                end
                if (wready) wr_cnt++;
                if (ccff_shift_en) begin
                    if (exp_bits.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_shift: actual shift at cycle %0d, required none", cyc);
                    end else begin
                        b = exp_bits.pop_front();
                        chk("head_bit", 32'(ccff_head), 32'(b));
                        exp_chain = {exp_chain[14:0], b};
                    end
                    nshift++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                if (done) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done: actual done at cycle %0d, required none", cyc);
                    end else begin
                        r = exp_q.pop_front();
                        chk("shift_count", nshift, r.len);
                        chk("bits_left", exp_bits.size(), 0);
                        e = (r.len == 0) ? 1'b0 : (exp_chain[15] != r.first);
                        chk("err_at_done", 32'(err), 32'(e));
                        chk("busy_in_done", 32'(busy), 32'd0);
                        if (r.len == 0) begin
                            chk("zero_len_latency", cyc - start_cyc, 1);
                            chk("zero_len_wready", wr_cnt, 0);
                        end else begin
                            if (r.timed) chk("done_latency", cyc - first_cyc, r.len + 2);
                            if (r.exp_stalls >= 0)
                                chk("stall_cycles", last_cyc - first_cyc + 1 - nshift, r.exp_stalls);
                        end
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        logic ok = 1'b0;
        wvalid = 1'b1;
        wdata  = w;
        for (int n = 0; n < 200; n++) begin
            if (wready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        wvalid = 1'b0;
        if (!ok) chk("wready_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_load(input int len, input int stalls, input logic timed);
        rec_t r;
        r.len = len;
        r.first = (len > 0) ? wq[0][0] : 1'b0;
        r.exp_stalls = stalls;
        r.timed = timed;
        exp_q.push_back(r);
        for (int i = 0; i < len; i++) exp_bits.push_back(wq[i / 32][i % 32]);
    endtask

    task automatic pulse_start(input int len);
        start = 1'b1;
        chain_len = 16'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        logic ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done_seen > d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic run_load(input int len, input int stalls, input logic timed);
        int d0 = done_seen;
        int nw = (len + 31) / 32;
        expect_load(len, stalls, timed);
        pulse_start(len);
        for (int i = 0; i < nw; i++) begin
            repeat (gq[i]) tick();
            send_word(wq[i]);
        end
        wait_done(d0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_wready"}, 32'(wready), 32'd0);
        chk({tag, "_head"}, 32'(ccff_head), 32'd0);
        chk({tag, "_shift_en"}, 32'(ccff_shift_en), 32'd0);
    endtask

    initial begin
        int d0;
        int len;
        logic mode;
        logic ok;

        repeat (3) tick();
        check_all_zero("in_reset");
        reset = 1'b0;
        repeat (2) tick();
        check_all_zero("after_reset");

        // Continuous stream: 40 bits, second word truncated after 8 bits.
        wq = {32'h0000_0001, 32'h0000_00FF};
        gq = {0, 0};
        run_load(40, 0, 1'b1);

        // Host pause: five bubble cycles between the two words.
        wq = {$urandom(), $urandom()};
        gq = {0, 36};
        run_load(64, 5, 1'b0);

        // Tail check: full-length load matches, one-short load does not.
        wq = {32'h0000_0001};
        gq = {0};
        run_load(16, 0, 1'b1);
        run_load(15, 0, 1'b1);
        repeat (3) tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Zero-length load goes straight to DONE.
        wq = {};
        gq = {};
        run_load(0, -1, 1'b0);

        // Start during LOAD must not disturb the running load.
        wq = {$urandom(), $urandom()};
        d0 = done_seen;
        expect_load(40, 0, 1'b1);
        pulse_start(40);
        send_word(wq[0]);
        start = 1'b1;
        chain_len = 16'd5;
        send_word(wq[1]);
        start = 1'b0;
        chain_len = 16'd0;
        wait_done(d0);

        // Reset in the middle of a load, then a fresh load.
        wq = {$urandom(), $urandom()};
        expect_load(40, 0, 1'b1);
        pulse_start(40);
        send_word(wq[0]);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (nshift >= 10) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("shift10_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_bits.delete();
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        wq = {$urandom()};
        gq = {0};
        run_load(8, 0, 1'b1);

        // Randomized loads, some with host pauses.
        for (int k = 0; k < 12; k++) begin
            len  = int'($urandom_range(1, 100));
            mode = 1'($urandom_range(0, 1));
            wq = {};
            gq = {};
            for (int i = 0; i < (len + 31) / 32; i++) begin
                wq.push_back($urandom());
                if (i == 0) gq.push_back(int'($urandom_range(0, 2)));
                else gq.push_back(mode ? 0 : int'($urandom_range(0, 40)));
            end
            run_load(len, mode ? 0 : -1, mode);
        end

        repeat (3) tick();
        chk("queues_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running at cycle %0d, required finished", cyc);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ccff_bitstream_loader

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows.
- prog_clk  in  1  configuration clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
REQ-002 The block SHALL have the following control ports.
- start  in  1  one-cycle load request, sampled in IDLE only
- chain_len  in  16  number of configuration bits in the chain, sampled with start
- busy  out  1  high from the cycle after an accepted start until DONE is entered
- done  out  1  one-cycle pulse on entry to DONE
- err  out  1  sticky tail-check mismatch; cleared by the next accepted start
REQ-003 The block SHALL have the following host word-stream ports.
- wdata  in  32  configuration word, LSB shifted first
- wvalid  in  1  host has a word
- wready  out  1  block accepts the word; transfer when wvalid and wready
REQ-004 The block SHALL have the following chain-side ports.
- ccff_head  out  1  serial bit into the chain
- ccff_shift_en  out  1  chain advances on this prog_clk edge
- ccff_tail  in  1  serial bit out of the chain end

Function
REQ-005 The block SHALL have FSM states IDLE, LOAD, CHECK and DONE.
- IDLE to LOAD on start with chain_len>0.
- IDLE to DONE on start with chain_len=0; err stays 0.
- LOAD to CHECK after the chain_len-th shift.
- CHECK to DONE after 1 cycle.
- DONE to IDLE after 1 cycle.
REQ-006 Datapath SHALL be a one-word buffer (buf, buf_valid), a 32-bit shift register (shreg), a 6-bit count of valid bits in shreg, and a 16-bit remaining-bits counter.
REQ-007 wready SHALL equal (state==LOAD) and !buf_valid; wready SHALL be 0 in IDLE, CHECK and DONE.
REQ-008 In LOAD, when shreg is empty, or shreg holds 1 bit and shifts this cycle, shreg SHALL reload from buf if buf_valid, else directly from an accepted wdata.
REQ-009 ccff_head SHALL equal shreg[0] while the shreg bit count is >0, else 0.
REQ-010 ccff_shift_en SHALL equal (state==LOAD) and (shreg bit count>0) and (remaining>0); each asserted cycle shifts shreg right by 1 and decrements remaining.
REQ-011 With wvalid held high, ccff_shift_en SHALL stay high continuously from the first shift to the last, with no bubble at word boundaries.
REQ-012 When buf and shreg are both empty in LOAD, ccff_shift_en SHALL be 0 (stall); there is no timeout.
REQ-013 On the first shift, the block SHALL store ccff_head as first_bit.
REQ-014 In CHECK, the block SHALL set err if ccff_tail != first_bit.
REQ-015 Bits of the final word beyond chain_len SHALL be discarded; buf SHALL be cleared on entry to CHECK, and the surplus is not returned to the host.
REQ-016 start outside IDLE SHALL be ignored, and chain_len SHALL be sampled only when start is accepted.
REQ-017 Latency: a word accepted at edge k SHALL drive its bit 0 on ccff_head with ccff_shift_en=1 in cycle k+1 if shreg is empty.
REQ-018 The block SHALL reach DONE exactly chain_len+2 cycles after the first shift when no stalls occur.

Reset
REQ-019 On reset the block SHALL enter IDLE and clear counters, buf_valid and first_bit.
REQ-020 On reset busy, done, err, wready, ccff_head and ccff_shift_en SHALL all be 0.
REQ-021 A reset asserted mid-LOAD SHALL abort immediately and drop partial words; the chain contents are then undefined and the host SHALL reissue start.

Structure
REQ-022 A shared package ccff_loader_pkg SHALL hold the state enum, WORD_W=32 and LEN_W=16.
REQ-023 The word buffer and shift register SHALL be one sub-module, ccff_word_serializer; the FSM and counters SHALL stay in the top module.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Continuous stream: chain_len=40, wdata=0x0000_0001 then 0x0000_00FF, wvalid high -> 40 contiguous ccff_shift_en cycles; head sequence 1,0x31,1x8; bits 8..31 of word 2 dropped; done at first-shift+42.
- Stall: chain_len=64, wvalid low for 5 cycles between words -> ccff_shift_en low exactly those cycles; 64 shifts total.
- Tail check: 16-flop chain model, chain_len=16, first bit 1 -> err=0; repeat with chain_len=15 -> err=1.
- Zero length: chain_len=0 -> done 1 cycle after start; no shift; wready never 1.
- Mid-load reset: assert reset after 10 shifts -> all outputs 0 and IDLE; new start with chain_len=8 completes normally with err cleared.
- Ignored start: pulse start during LOAD -> no effect on counters or chain_len.
